wb_host_master: RTL and testbench



---
 rtl/wb_master_pkg.sv | 29 ++
 rtl/wb_timeout_ctr.sv | 41 ++++
 rtl/wb_host_master.sv | 100 ++++++++++
 tb/tb_wb_host_master.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and sizes for the user-area Wishbone host master.
package wb_master_pkg;

  localparam int unsigned WB_AW              = 32;
  localparam int unsigned WB_DW              = 32;
  localparam int unsigned WB_SW              = 4;
  localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } wb_state_e;

  // Latched command as it appears on the bus.
  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

  // Response payload returned to the command issuer.
  typedef struct packed {
    logic             err;
    logic [WB_DW-1:0] dat;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Clear/enable saturating counter of unacknowledged strobe cycles.
// expired is registered and is high during the last strobe cycle allowed before timeout.
module wb_timeout_ctr
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW1-1:0] LAST  = CW1'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0]  cnt;
  logic [CW1-1:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt} + CW1'(1);

  // expired looks one count ahead so the FSM can leave BUS on the Nth strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= (TIMEOUT_CYCLES == 1);
    end else if (enable) begin
      if (cnt != LIMIT) begin
        cnt <= cnt + CW'(1);
      end
      expired <= expired || (cnt_inc >= LAST);
    end
  end

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command channel,
// returning read data or a timeout error on a valid/ready response channel.
module wb_host_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  input  logic [WB_DW-1:0] wbm_dat_i,
  input  logic             wbm_ack_i
);

  wb_state_e state;
  wb_req_t   req_q;
  wb_rsp_t   rsp_q;
  logic      cyc_q;
  logic      rsp_valid_q;
  logic      expired;

  // Bus payload register is zeroed whenever cyc is low, so outputs read 0 outside BUS.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = req_q.we;
  assign wbm_adr_o = req_q.adr;
  assign wbm_dat_o = req_q.dat;
  assign wbm_sel_o = req_q.sel;

  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_q.dat;
  assign rsp_err   = rsp_q.err;

  assign cmd_ready = (state == IDLE) && !wb_rst_i;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (state == IDLE),
    .enable ((state == BUS) && !wbm_ack_i),
    .expired(expired)
  );

  // Control FSM with command latch and response register; ack takes priority over timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            req_q <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
            cyc_q <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          if (wbm_ack_i || expired) begin
            rsp_q.err   <= !wbm_ack_i;
            rsp_q.dat   <= (wbm_ack_i && !req_q.we) ? wbm_dat_i : '0;
            rsp_valid_q <= 1'b1;
            cyc_q       <= 1'b0;
            req_q       <= '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboarded bench for wb_host_master with TIMEOUT_CYCLES=4 and a scripted slave.
module tb_wb_host_master;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_rsp_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  int total;
  int bad;
  exp_rsp_t sb[$];

  wb_host_master #(.TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
    end
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 71'd0) begin
      bad++; $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h want all 0", wbm_cyc_o, wbm_stb_o, wbm_adr_o);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_dat} !== 34'd0) begin
      bad++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_dat);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    logic [70:0] exp_bus;
    exp_bus = {1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF};
    rsp_ready = 1'b1;
    drive_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'h0});
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      total++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== exp_bus) begin
        bad++; $display("FAIL write_bus_c%0d: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want 1 1 1 30000004 a5a51234 f",
                        c, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
      end
      total++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        bad++; $display("FAIL write_busy_c%0d: got ready=%b rsp_valid=%b want 0 0", c, cmd_ready, rsp_valid);
      end
      wbm_ack_i = (c == 3);
      if (c < 3) tick();
    end
    tick();
    wbm_ack_i = 1'b0;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 71'd0) begin
      bad++; $display("FAIL write_bus_release: got cyc=%b stb=%b adr=%h dat=%h want 0", wbm_cyc_o, wbm_stb_o, wbm_adr_o, wbm_dat_o);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL write_rsp: got v=%b e=%b d=%h want 1 0 0", rsp_valid, rsp_err, rsp_dat);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL write_return_idle: got rsp_valid=%b ready=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_zero_wait();
    rsp_ready = 1'b1;
    drive_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'hDEAD_BEEF});
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o} !== {1'b1, 1'b1, 1'b0, 32'h3000_0010}) begin
      bad++; $display("FAIL read0_bus_c1: got cyc=%b stb=%b we=%b adr=%h want 1 1 0 30000010", wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hDEAD_BEEF;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    total++;
    if ({wbm_stb_o, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL read0_rsp_c2: got stb=%b v=%b e=%b d=%h want 0 1 0 deadbeef", wbm_stb_o, rsp_valid, rsp_err, rsp_dat);
    end
    tick();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL read0_ready_c3: got %b want 1", cmd_ready);
    end
    drive_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3);
    sb.push_back('{err: 1'b0, dat: 32'h0123_4567});
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wbm_stb_o, wbm_adr_o, wbm_sel_o} !== {1'b1, 32'h3000_0020, 4'h3}) begin
      bad++; $display("FAIL read0_next_accept: got stb=%b adr=%h sel=%h want 1 30000020 3", wbm_stb_o, wbm_adr_o, wbm_sel_o);
    end
    tick();
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0123_4567;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    total++;
    if ({rsp_valid, rsp_dat} !== {1'b1, 32'h0123_4567}) begin
      bad++; $display("FAIL read1_rsp: got v=%b d=%h want 1 01234567", rsp_valid, rsp_dat);
    end
    tick();
  endtask

  task automatic test_timeout();
    int stb_cycles;
    rsp_ready = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    drive_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    sb.push_back('{err: 1'b1, dat: 32'h0});
    tick();
    cmd_valid  = 1'b0;
    stb_cycles = 0;
    while (wbm_stb_o === 1'b1 && stb_cycles < 20) begin
      stb_cycles++;
      tick();
    end
    total++;
    if (stb_cycles !== 4) begin
      bad++; $display("FAIL timeout_stb_len: got %0d cycles want 4", stb_cycles);
    end
    total++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_dat);
    end
    tick();
    wbm_dat_i = 32'h0;
    drive_cmd(1'b0, 32'h3000_0044, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'hCAFE_F00D});
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (wbm_stb_o !== 1'b1) begin
      bad++; $display("FAIL timeout_stb_c4: got %b want 1", wbm_stb_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    total++;
    if ({wbm_stb_o, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b0, 32'hCAFE_F00D}) begin
      bad++; $display("FAIL timeout_ack_wins: got stb=%b v=%b e=%b d=%h want 0 1 0 cafef00d", wbm_stb_o, rsp_valid, rsp_err, rsp_dat);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'h5A5A_0F0F});
    tick();
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h5A5A_0F0F;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o} !== {1'b1, 1'b0, 32'h5A5A_0F0F, 1'b0, 1'b0}) begin
        bad++; $display("FAIL bp_hold_%0d: got v=%b e=%b d=%h ready=%b cyc=%b want 1 0 5a5a0f0f 0 0",
                        c, rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc_o);
      end
      wbm_ack_i = (c == 1);
      wbm_dat_i = (c == 1) ? 32'hFFFF_FFFF : 32'h0;
      tick();
    end
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc_o !== 1'b0) begin
      bad++; $display("FAIL bp_release: got v=%b ready=%b cyc=%b want 0 1 0", rsp_valid, cmd_ready, wbm_cyc_o);
    end
  endtask

  task automatic test_reset_mid_transfer();
    rsp_ready = 1'b1;
    drive_cmd(1'b0, 32'h3000_0080, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    total++;
    if (wbm_stb_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_stb_c2: got %b want 1", wbm_stb_o);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_abort: got cyc=%b stb=%b v=%b ready=%b want 0 0 0 0", wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready);
    end
    drive_cmd(1'b0, 32'h3000_0084, 32'h0, 4'hF);
    sb.push_back('{err: 1'b0, dat: 32'h7777_8888});
    tick();
    cmd_valid = 1'b0;
    total++;
    if ({wbm_stb_o, wbm_adr_o} !== {1'b1, 32'h3000_0084}) begin
      bad++; $display("FAIL rstmid_next_bus: got stb=%b adr=%h want 1 30000084", wbm_stb_o, wbm_adr_o);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_8888;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    total++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h7777_8888}) begin
      bad++; $display("FAIL rstmid_next_rsp: got v=%b e=%b d=%h want 1 0 77778888", rsp_valid, rsp_err, rsp_dat);
    end
    tick();
  endtask

  initial begin
    exp_rsp_t exp_r;
    int       left;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    wbm_dat_i = 32'h0;
    wbm_ack_i = 1'b0;

    // Response monitor: every handshake pops the oldest expected response.
    fork
      forever begin
        @(negedge clk);
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++; $display("FAIL sb_unexpected_rsp: got e=%b d=%h want no response", rsp_err, rsp_dat);
          end else begin
            exp_r = sb.pop_front();
            if ({rsp_err, rsp_dat} !== {exp_r.err, exp_r.dat}) begin
              bad++; $display("FAIL sb_rsp: got e=%b d=%h want e=%b d=%h", rsp_err, rsp_dat, exp_r.err, exp_r.dat);
            end
          end
        end
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_write();
    test_read_zero_wait();
    test_timeout();
    test_backpressure();
    test_reset_mid_transfer();
    tick();

    left = sb.size();
    total++;
    if (left !== 0) begin
      bad++; $display("FAIL sb_drained: got %0d pending want 0", left);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
